// File: rtl/dm_ctrl.sv
// Data-memory controller: word RAM split into four byte lanes behind a
// req/ready/done handshake, with sub-word access, load extension and error reporting.

module dm_lane #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_idx,
  input  logic [7:0]    i_wd,
  output logic [7:0]    o_rd
);
  logic [7:0] r_mem [2**AW];

  // Contents are deliberately not reset.
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_idx] <= i_wd;

  assign o_rd = r_mem[i_idx];
endmodule

module dm_ctrl #(
  parameter int AW      = 8,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          sext;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic          err;
  } req_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  req_t r_req;
  logic r_err;
  logic [31:0] r_rdata;

  logic w_acc, w_commit, w_wr, w_bad;
  logic [3:0] w_be;
  logic [3:0][7:0] w_wd, w_rd;
  logic [31:0] w_word, w_sh, w_ld;

  assign o_ready  = (r_state != BUSY);
  assign o_done   = (r_state == DONE);
  assign o_err    = o_done & r_err;
  assign o_rdata  = r_rdata;
  assign w_acc    = i_req & o_ready;
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);

  // Reserved size, misalignment, or address beyond the RAM.
  assign w_bad = (i_size == 2'b11) ||
                 (i_size == 2'b01 && i_addr[0]) ||
                 (i_size == 2'b10 && i_addr[1:0] != 2'b00) ||
                 (|(i_addr >> (AW + 2)));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (w_acc) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      BUSY:
        if (r_cnt == 4'd0) w_state_nxt = DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_req <= '0;
    else if (w_acc)
      r_req <= '{we: i_we, size: i_size, sext: i_sext, lane: i_addr[1:0],
                 idx: i_addr[AW+1:2], wdata: i_wdata, err: w_bad};

  // Store data is replicated across lanes; byte enables pick the live ones.
  always_comb begin
    w_be = 4'b1111;
    w_wd = r_req.wdata;
    case (r_req.size)
      2'b00: begin
        w_be = 4'b0001 << r_req.lane;
        w_wd = {4{r_req.wdata[7:0]}};
      end
      2'b01: begin
        w_be = r_req.lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{r_req.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_wr = w_commit & r_req.we & ~r_req.err;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dm_lane #(.AW(AW)) u_lane (
      .i_clk (i_clk),
      .i_we  (w_wr & w_be[g]),
      .i_idx (r_req.idx),
      .i_wd  (w_wd[g]),
      .o_rd  (w_rd[g])
    );
  end

  assign w_word = w_rd;
  assign w_sh   = w_word >> {r_req.lane, 3'b000};

  always_comb begin
    w_ld = w_word;
    case (r_req.size)
      2'b00:   w_ld = {{24{r_req.sext & w_sh[7]}},  w_sh[7:0]};
      2'b01:   w_ld = {{16{r_req.sext & w_sh[15]}}, w_sh[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_commit) begin
      r_err <= r_req.err;
      if (r_req.err)      r_rdata <= '0;
      else if (!r_req.we) r_rdata <= w_ld;
    end
endmodule
